// File: rtl/tpx3_ext_sync_pkg.sv
// Shared types and constants for the Ext1 T0_Sync/Reset receiver.
package tpx3_ext_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DLY      = 2'd1,
        ST_PULSE    = 2'd2,
        ST_WAIT_LOW = 2'd3
    } chan_state_e;

    localparam int EVT_CNT_W   = 16;
    localparam int DROP_CNT_W  = 8;
    localparam int SYNC_DEPTH  = 2;
    localparam int FILT_CNT_W  = 4;
    localparam int PULSE_CNT_W = 4;

endpackage

// File: rtl/tpx3_ext_sync_chan.sv
// One receive channel: synchroniser, high-level filter, delay/pulse FSM and event counter.
// Valid/ready is not used here; accept_o is a single-cycle strobe in the cycle the FSM leaves IDLE on a filtered edge.
module tpx3_ext_sync_chan
    import tpx3_ext_sync_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int PULSE_LEN  = 1,
    parameter int DELAY_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic                 line_i,
    input  logic                 inhibit_i,
    input  logic                 abort_i,
    output logic                 pulse_o,
    output logic                 accept_o,
    output chan_state_e          state_o,
    output logic [EVT_CNT_W-1:0] cnt_o
);

    localparam logic [FILT_CNT_W-1:0]  FILT_MAX   = FILT_CNT_W'(FILTER_LEN);
    localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(PULSE_LEN - 1);

    logic [SYNC_DEPTH-1:0]  sync_q;
    logic                   line_s;
    logic [FILT_CNT_W-1:0]  filt_q, filt_d;
    logic [DELAY_W-1:0]     dly_q, dly_d;
    logic [PULSE_CNT_W-1:0] pcnt_q, pcnt_d;
    logic [EVT_CNT_W-1:0]   cnt_q, cnt_d;
    chan_state_e            state_q, state_d;

    assign line_s   = sync_q[SYNC_DEPTH-1];
    assign accept_o = (state_q == ST_IDLE) && (filt_q == FILT_MAX) && enable_i;
    assign pulse_o  = (state_q == ST_PULSE);
    assign state_o  = state_q;
    assign cnt_o    = cnt_q;

    always_comb begin
        filt_d = filt_q;
        if (!line_s) begin
            filt_d = '0;
        end else if (filt_q != FILT_MAX) begin
            filt_d = filt_q + FILT_CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            // Disabled: park until the line is seen low so re-enable cannot fire on a held line.
            if ((state_q == ST_IDLE || state_q == ST_WAIT_LOW) && !line_s) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_WAIT_LOW;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_o) begin
                        if (inhibit_i) begin
                            state_d = ST_WAIT_LOW;
                        end else if (delay_i == '0) begin
                            state_d = ST_PULSE;
                            pcnt_d  = '0;
                        end else begin
                            state_d = ST_DLY;
                            dly_d   = delay_i;
                        end
                    end
                end
                ST_DLY: begin
                    dly_d = dly_q - DELAY_W'(1);
                    if (abort_i) begin
                        state_d = ST_WAIT_LOW;
                    end else if (dly_q == DELAY_W'(1)) begin
                        state_d = ST_PULSE;
                        pcnt_d  = '0;
                    end
                end
                ST_PULSE: begin
                    if (abort_i) begin
                        state_d = ST_WAIT_LOW;
                    end else begin
                        if (pcnt_q == '0) begin
                            cnt_d = cnt_q + EVT_CNT_W'(1);
                        end
                        if (pcnt_q == PULSE_LAST) begin
                            state_d = ST_WAIT_LOW;
                        end else begin
                            pcnt_d = pcnt_q + PULSE_CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (!line_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            filt_q  <= '0;
            dly_q   <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_DEPTH-2:0], line_i};
            filt_q  <= filt_d;
            dly_q   <= dly_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/tpx3_ext_sync_rx.sv
// Client-side T0_Sync/Reset receiver: two channels, reset-over-T0 priority, drop counter, BUSY.
// Optional Ext2 echo outputs are built when TPX3_EXT_SYNC_ECHO_EN is defined.
module tpx3_ext_sync_rx
    import tpx3_ext_sync_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int PULSE_LEN  = 1,
    parameter int DELAY_W    = 8
) (
    input  logic                  CLK40,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [DELAY_W-1:0]    DELAY,
    input  logic                  T0_SYNC_EXT,
    input  logic                  RESET_EXT,
    output logic                  T0_SYNC_OUT,
    output logic                  RESET_OUT,
    output logic [EVT_CNT_W-1:0]  T0_CNT,
    output logic [EVT_CNT_W-1:0]  RESET_CNT,
    output logic [DROP_CNT_W-1:0] T0_DROP_CNT,
    output logic                  BUSY
`ifdef TPX3_EXT_SYNC_ECHO_EN
    ,
    output logic                  T0_SYNC_ECHO,
    output logic                  RESET_ECHO
`endif
);

    logic                  t0_accept, rst_accept;
    logic                  t0_inhibit, t0_drop;
    chan_state_e           t0_state, rst_state;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // Reset wins: a T0 acceptance is discarded while reset pulses or in the cycle reset is accepted.
    assign t0_inhibit = RESET_OUT | rst_accept;
    assign t0_drop    = (t0_accept & t0_inhibit)
                      | (rst_accept & ((t0_state == ST_DLY) || (t0_state == ST_PULSE)));

    tpx3_ext_sync_chan #(
        .FILTER_LEN (FILTER_LEN),
        .PULSE_LEN  (PULSE_LEN),
        .DELAY_W    (DELAY_W)
    ) u_t0_chan (
        .clk_i     (CLK40),
        .rst_i     (RST),
        .enable_i  (ENABLE),
        .delay_i   (DELAY),
        .line_i    (T0_SYNC_EXT),
        .inhibit_i (t0_inhibit),
        .abort_i   (rst_accept),
        .pulse_o   (T0_SYNC_OUT),
        .accept_o  (t0_accept),
        .state_o   (t0_state),
        .cnt_o     (T0_CNT)
    );

    tpx3_ext_sync_chan #(
        .FILTER_LEN (FILTER_LEN),
        .PULSE_LEN  (PULSE_LEN),
        .DELAY_W    (DELAY_W)
    ) u_rst_chan (
        .clk_i     (CLK40),
        .rst_i     (RST),
        .enable_i  (ENABLE),
        .delay_i   (DELAY),
        .line_i    (RESET_EXT),
        .inhibit_i (1'b0),
        .abort_i   (1'b0),
        .pulse_o   (RESET_OUT),
        .accept_o  (rst_accept),
        .state_o   (rst_state),
        .cnt_o     (RESET_CNT)
    );

    always_comb begin
        drop_d = drop_q;
        if (t0_drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign T0_DROP_CNT = drop_q;
    assign BUSY        = (t0_state != ST_IDLE) || (rst_state != ST_IDLE);

`ifdef TPX3_EXT_SYNC_ECHO_EN
    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            T0_SYNC_ECHO <= 1'b0;
            RESET_ECHO   <= 1'b0;
        end else begin
            T0_SYNC_ECHO <= T0_SYNC_OUT;
            RESET_ECHO   <= RESET_OUT;
        end
    end
`else
    // No echo: the Ext2 pins are left to other logic.
`endif

endmodule

// File: tb/tb_tpx3_ext_sync_rx.sv
// Directed bench for tpx3_ext_sync_rx: one PULSE_LEN=1 instance and one PULSE_LEN=4 instance share stimulus.
module tb_tpx3_ext_sync_rx;

  logic        clk40 = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  delay;
  logic        t0_ext;
  logic        rst_ext;

  logic        a_t0_out, a_rst_out, a_busy;
  logic [15:0] a_t0_cnt, a_rst_cnt;
  logic [7:0]  a_drop;
  logic        b_t0_out, b_rst_out, b_busy;
  logic [15:0] b_t0_cnt, b_rst_cnt;
  logic [7:0]  b_drop;
`ifdef TPX3_EXT_SYNC_ECHO_EN
  logic        a_t0_echo, a_rst_echo, b_t0_echo, b_rst_echo;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk40 = ~clk40;

  tpx3_ext_sync_rx u_dut (
    .CLK40       (clk40),
    .RST         (rst),
    .ENABLE      (enable),
    .DELAY       (delay),
    .T0_SYNC_EXT (t0_ext),
    .RESET_EXT   (rst_ext),
    .T0_SYNC_OUT (a_t0_out),
    .RESET_OUT   (a_rst_out),
    .T0_CNT      (a_t0_cnt),
    .RESET_CNT   (a_rst_cnt),
    .T0_DROP_CNT (a_drop),
    .BUSY        (a_busy)
`ifdef TPX3_EXT_SYNC_ECHO_EN
    ,
    .T0_SYNC_ECHO (a_t0_echo),
    .RESET_ECHO   (a_rst_echo)
`endif
  );

  tpx3_ext_sync_rx #(.PULSE_LEN(4)) u_dut4 (
    .CLK40       (clk40),
    .RST         (rst),
    .ENABLE      (enable),
    .DELAY       (delay),
    .T0_SYNC_EXT (t0_ext),
    .RESET_EXT   (rst_ext),
    .T0_SYNC_OUT (b_t0_out),
    .RESET_OUT   (b_rst_out),
    .T0_CNT      (b_t0_cnt),
    .RESET_CNT   (b_rst_cnt),
    .T0_DROP_CNT (b_drop),
    .BUSY        (b_busy)
`ifdef TPX3_EXT_SYNC_ECHO_EN
    ,
    .T0_SYNC_ECHO (b_t0_echo),
    .RESET_ECHO   (b_rst_echo)
`endif
  );

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk40);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; delay = 8'd0; t0_ext = 1'b0; rst_ext = 1'b0;
    tick(2);
    chk("rst_t0_out", {31'd0, a_t0_out}, 32'd0);
    chk("rst_rst_out", {31'd0, a_rst_out}, 32'd0);
    chk("rst_t0_cnt", {16'd0, a_t0_cnt}, 32'd0);
    chk("rst_rst_cnt", {16'd0, a_rst_cnt}, 32'd0);
    chk("rst_drop", {24'd0, a_drop}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    rst = 1'b0; enable = 1'b1;
    tick(3);

    // basic T0: rises 6 edges after the first sampling edge
    t0_ext = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("basic_t0_out", {31'd0, a_t0_out}, {31'd0, i == 6});
      chk("basic_t0_out4", {31'd0, b_t0_out}, {31'd0, i >= 6 && i <= 9});
    end
    chk("basic_t0_cnt", {16'd0, a_t0_cnt}, 32'd1);
    chk("basic_busy_held", {31'd0, a_busy}, 32'd1);
    t0_ext = 1'b0;
    tick(4);
    chk("basic_busy_idle", {31'd0, a_busy}, 32'd0);

    // glitch rejection: 2 high, 1 low, 1 high
    t0_ext = 1'b1; tick(2);
    t0_ext = 1'b0; tick(1);
    t0_ext = 1'b1; tick(1);
    t0_ext = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk("glitch_t0_out", {31'd0, a_t0_out}, 32'd0);
      chk("glitch_busy", {31'd0, a_busy}, 32'd0);
    end
    chk("glitch_t0_cnt", {16'd0, a_t0_cnt}, 32'd1);

    // programmable delay: DELAY=5, changed to 0 while in DLY
    delay = 8'd5; rst_ext = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      chk("dly_rst_out", {31'd0, a_rst_out}, {31'd0, i == 11});
      chk("dly_rst_out4", {31'd0, b_rst_out}, {31'd0, i >= 11 && i <= 14});
      if (i == 7) delay = 8'd0;
    end
    chk("dly_rst_cnt", {16'd0, a_rst_cnt}, 32'd1);
    chk("dly_rst_cnt4", {16'd0, b_rst_cnt}, 32'd1);
    chk("dly_drop", {24'd0, a_drop}, 32'd0);
    rst_ext = 1'b0;
    tick(4);

    // reset priority: both lines rise together
    t0_ext = 1'b1; rst_ext = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("prio_t0_out", {31'd0, a_t0_out}, 32'd0);
      chk("prio_rst_out", {31'd0, a_rst_out}, {31'd0, i == 6});
    end
    chk("prio_drop", {24'd0, a_drop}, 32'd1);
    chk("prio_t0_cnt", {16'd0, a_t0_cnt}, 32'd1);
    chk("prio_rst_cnt", {16'd0, a_rst_cnt}, 32'd2);
    t0_ext = 1'b0; rst_ext = 1'b0;
    tick(4);
    t0_ext = 1'b1;
    tick(6);
    chk("prio_next_t0_out", {31'd0, a_t0_out}, 32'd1);
    t0_ext = 1'b0;
    tick(6);
    chk("prio_next_t0_cnt", {16'd0, a_t0_cnt}, 32'd2);
    chk("prio_next_drop", {24'd0, a_drop}, 32'd1);

    // ENABLE dropped mid-pulse on the PULSE_LEN=4 instance
    t0_ext = 1'b1;
    tick(7);
    chk("en_pre_out4", {31'd0, b_t0_out}, 32'd1);
    enable = 1'b0;
    tick(1);
    chk("en_off_out4", {31'd0, b_t0_out}, 32'd0);
    chk("en_off_cnt4", {16'd0, b_t0_cnt}, 32'd3);
    tick(3);
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk("en_held_out", {31'd0, a_t0_out}, 32'd0);
      chk("en_held_out4", {31'd0, b_t0_out}, 32'd0);
    end
    chk("en_held_busy", {31'd0, a_busy}, 32'd1);
    chk("en_held_cnt", {16'd0, a_t0_cnt}, 32'd3);
    t0_ext = 1'b0;
    tick(4);
    chk("en_idle_busy", {31'd0, a_busy}, 32'd0);

    // reset accepted while T0 is mid-pulse (PULSE_LEN=4 instance aborts)
    t0_ext = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk("abort_t0_out", {31'd0, a_t0_out}, {31'd0, i == 6});
      chk("abort_t0_out4", {31'd0, b_t0_out}, {31'd0, i == 6 || i == 7});
      chk("abort_rst_out4", {31'd0, b_rst_out}, {31'd0, i >= 8 && i <= 11});
      if (i == 2) rst_ext = 1'b1;
    end
    chk("abort_drop", {24'd0, a_drop}, 32'd1);
    chk("abort_drop4", {24'd0, b_drop}, 32'd2);
    chk("abort_t0_cnt4", {16'd0, b_t0_cnt}, 32'd4);
    chk("abort_rst_cnt4", {16'd0, b_rst_cnt}, 32'd3);
    t0_ext = 1'b0; rst_ext = 1'b0;
    tick(6);

    // asynchronous RST during PULSE
    t0_ext = 1'b1;
    tick(6);
    chk("arst_pre_out4", {31'd0, b_t0_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out4", {31'd0, b_t0_out}, 32'd0);
    chk("arst_cnt4", {16'd0, b_t0_cnt}, 32'd0);
    chk("arst_rst_cnt4", {16'd0, b_rst_cnt}, 32'd0);
    chk("arst_drop4", {24'd0, b_drop}, 32'd0);
    chk("arst_busy4", {31'd0, b_busy}, 32'd0);
    t0_ext = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);

    // wrap: preload T0_CNT to 0xFFFF, one more event rolls it to 0
    force u_dut.u_t0_chan.cnt_q = 16'hFFFF;
    tick(1);
    release u_dut.u_t0_chan.cnt_q;
    tick(1);
    chk("wrap_preload", {16'd0, a_t0_cnt}, 32'h0000FFFF);
    t0_ext = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk("wrap_t0_out", {31'd0, a_t0_out}, {31'd0, i == 6});
`ifdef TPX3_EXT_SYNC_ECHO_EN
      chk("wrap_t0_echo", {31'd0, a_t0_echo}, {31'd0, i == 7});
      chk("wrap_t0_echo4", {31'd0, b_t0_echo}, {31'd0, i >= 7 && i <= 10});
`endif
    end
    chk("wrap_t0_cnt", {16'd0, a_t0_cnt}, 32'd0);
    chk("wrap_t0_cnt4", {16'd0, b_t0_cnt}, 32'd1);
    t0_ext = 1'b0;
    tick(4);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tpx3_ext_sync_rx.md
Name: tpx3_ext_sync_rx

Overview:
- Client-side receiver for the board-to-board T0_Sync/Reset distribution that a host-build FEC drives out on its Ext1/Ext2 pins.
- Sits in the client build between the raw Ext1 input pins and the chip-side T0_Sync/Reset drivers.
- Synchronises and deglitches both lines, then compensates cable skew with a programmable delay.
- Regenerates clean, fixed-width pulses on CLK40 and counts accepted events.

Parameters:
- FILTER_LEN, 3: consecutive synchronised-high cycles required to accept an edge; legal range 1..15.
- PULSE_LEN, 1: width of the regenerated output pulse in CLK40 cycles; legal range 1..15.
- DELAY_W, 8: width of the DELAY input.

Ports:
- CLK40  in  1  40 MHz chip clock; single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- ENABLE  in  1  receiver enable (from register file, already CLK40-synchronous).
- DELAY  in  DELAY_W  extra cycles inserted between acceptance and output.
- T0_SYNC_EXT  in  1  raw T0 sync line from host; asynchronous.
- RESET_EXT  in  1  raw reset line from host; asynchronous.
- T0_SYNC_OUT  out  1  regenerated T0 pulse.
- RESET_OUT  out  1  regenerated reset pulse.
- T0_CNT  out  16  accepted T0 events; wraps.
- RESET_CNT  out  16  accepted reset events; wraps.
- T0_DROP_CNT  out  8  T0 events discarded due to reset priority; saturates at 255.
- BUSY  out  1  high while either channel is not IDLE.

Behaviour:
- Clock and reset:
  - One clock, CLK40.
  - Reset is asynchronous and active-high: port RST.
  - On RST, all outputs, counters, synchronisers and state registers go to 0, and both channels go to IDLE.
- Synchroniser: each line passes through a 2-FF synchroniser (reset 0).
- Per-channel filter counter:
  - Increments while the synchronised line is high; clears when it is low.
  - Saturates at FILTER_LEN.
- Per-channel FSM: IDLE -> DLY -> PULSE -> WAIT_LOW -> IDLE.
  - IDLE: when the filter counter reaches FILTER_LEN and ENABLE=1, sample DELAY into the down-counter. Go to DLY if DELAY>0, else PULSE.
  - DLY: decrement each cycle; go to PULSE on the cycle after the count reaches 1.
  - PULSE: output high for exactly PULSE_LEN cycles; the event counter increments on the first PULSE cycle. Then go to WAIT_LOW.
  - WAIT_LOW: stay until the synchronised line is low, then go to IDLE. This blocks retriggering on a held-high line.
- Latency: the output rises exactly FILTER_LEN+DELAY+3 rising edges after the first edge that samples the raw input high.
- ENABLE=0:
  - Next cycle, both FSMs go to WAIT_LOW and outputs drop low, even mid-pulse.
  - Counters hold; the filter keeps running.
  - After re-enable, no pulse is generated until the line has been seen low.
- Reset priority:
  - While RESET_OUT=1, or in any cycle where the reset channel leaves IDLE, a T0 acceptance is discarded.
  - A discarded T0 goes to WAIT_LOW, T0_DROP_CNT increments (saturating), and T0_CNT is unchanged.
  - A T0 pulse already in DLY/PULSE when reset is accepted is aborted: output low next cycle, counted as a drop.
- DELAY change mid-operation: has no effect on an event already in DLY.
- Wrap: T0_CNT/RESET_CNT roll 0xFFFF -> 0x0000.

Optional Feature:
- Macro: TPX3_EXT_SYNC_ECHO_EN.
- Defined:
  - Adds outputs T0_SYNC_ECHO and RESET_ECHO (1 bit each, reset 0), driving the Ext2 pins for daisy-chaining.
  - Each echo equals the corresponding regenerated output registered once more (1-cycle later).
- Undefined: ports are absent; the Ext2 pins are not driven by this block.

Decomposition:
- Package tpx3_ext_sync_pkg:
  - FSM state encoding (IDLE=0, DLY=1, PULSE=2, WAIT_LOW=3).
  - Counter widths (16, 8).
  - Synchroniser depth constant (2).
- Sub-module tpx3_ext_sync_chan holds synchroniser, filter, FSM, pulse counter and event counter for one line. It is instantiated twice, with an abort/inhibit input for the T0 instance.
- The top level holds the priority logic, drop counter, BUSY, and the optional echo registers.

Test Plan:
- Basic T0 path: FILTER_LEN=3, PULSE_LEN=1, DELAY=0; T0_SYNC_EXT high 10 cycles.
  - T0_SYNC_OUT high for exactly 1 cycle, 6 edges after the first sampling edge.
  - T0_CNT=1; no second pulse while the line is held.
- Glitch rejection: T0_SYNC_EXT high 2 cycles, then 1 cycle, then low.
  - No output; T0_CNT=0; BUSY stays 0.
- Programmable delay: DELAY=5, PULSE_LEN=4; RESET_EXT held high 20 cycles.
  - RESET_OUT high cycles 11..14; RESET_CNT=1.
  - Changing DELAY to 0 during DLY does not move the pulse.
- Reset priority: raw T0 and RESET rise on the same edge (DELAY=0).
  - RESET_OUT pulses; T0_SYNC_OUT stays 0; T0_DROP_CNT=1.
  - Next T0 after the lines return low is accepted normally.
- Mid-operation abort: assert RST during PULSE (PULSE_LEN=8).
  - All outputs 0 immediately (asynchronous); counters 0.
  - With ENABLE deasserted mid-pulse instead: output low next cycle, counter retains 1.
- Wrap and echo: preload via 65535 events (or force).
  - T0_CNT rolls to 0.
  - With TPX3_EXT_SYNC_ECHO_EN defined, T0_SYNC_ECHO mirrors T0_SYNC_OUT delayed 1 cycle.
